multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Multi-cycle control sequencer for the RV32I datapath: replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back cycles. It drives the datapath's mux selects and write enables, stalls on a memory-ready handshake, flags unsupported opcodes, and counts retired instructions. It sits between the instruction register and the shared PC/IR/register-file/memory datapath.

## Interface
Parameters:
- INSTRUCTION_LEN, 32, instruction register width; opcode is bits [6:0].
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instruction  input  INSTRUCTION_LEN  IR contents; valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- zero  input  1  ALU zero flag, used in BRANCH.
- pc_write  output  1  PC load enable (includes taken branch).
- ir_write  output  1  IR load enable.
- adr_src  output  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register-file write enable.
- result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  output  2  00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct decode.
- illegal  output  1  sticky unsupported-opcode flag.
- state  output  4  current state encoding, for debug.
- retired  output  CNT_WIDTH  retired-instruction count.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, ILLEGAL 15. Any other encoding goes to FETCH on the next edge.
- Outputs are a Moore decode of the state. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready.
  - Holds while mem_ready=0, then goes to DECODE.
- DECODE:
  - Outputs: a=01, b=01, alu_op=00, so the branch/JAL target is computed into ALUOut.
  - Next state by opcode: 3 or 35 -> MEM_ADR; 51 -> EXEC_R; 19 -> EXEC_I; 99 -> BRANCH; 111 -> JAL (see Configuration); anything else -> ILLEGAL.
- MEM_ADR: a=10, b=01, alu_op=00. Goes to MEM_READ if opcode=3, else MEM_WRITE.
- MEM_READ: adr_src=1, mem_read=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Goes to FETCH.
- MEM_WRITE: adr_src=1, mem_write=1. Holds until mem_ready, then goes to FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Goes to ALU_WB.
- EXEC_I: a=10, b=01, alu_op=10. Goes to ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Goes to FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, so PC takes the target and old PC+4 is computed. Goes to ALU_WB.
- ILLEGAL: illegal=1, all enables 0. Stays until reset.
- retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH. It wraps modulo 2^CNT_WIDTH.

## Timing
- Reset values: state=FETCH (0), retired=0, illegal=0.
  - While rst_n=0, all enables (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0.
  - Selects are 0 while rst_n=0.
- Reset mid-instruction: the FSM aborts immediately and the counter is not incremented. Fetch resumes on the first edge after deassertion.
- Latency with mem_ready tied to 1:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Requests stay asserted and stable throughout the stall.
- mem_ready outside those three states is ignored.
- pc_write and ir_write in FETCH follow mem_ready combinationally in the same cycle.

## Configuration
- JAL_EN:
  - Defined: opcode 111 goes from DECODE to JAL, then ALU_WB.
  - Undefined: the JAL state is not built, and opcode 111 goes to ILLEGAL.

## Test plan
- Reset released, mem_ready=1, add x3,x1,x2 (opcode 51) -> states 0,1,6,8,0; reg_write=1 only in state 8; alu_op=10 in state 6; retired=1.
- lw (opcode 3) with mem_ready low for 2 cycles in MEM_READ -> mem_read and adr_src=1 held 3 cycles; 7 cycles total; reg_write with result_src=01 once.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in BRANCH only for the first; retired=2; no reg_write.
- Opcode 0x7F -> DECODE then ILLEGAL; illegal=1, enables 0 for 10 cycles; rst_n pulse clears illegal to 0 and state to 0.
- Opcode 111: with JAL_EN -> states 1,10,8,0 and pc_write in 10; without JAL_EN -> ILLEGAL.
- Preload retired to all-ones (CNT_WIDTH=4, 15 instructions), retire one more -> 0; assert rst_n low during MEM_ADR -> state 0 asynchronously, enables 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath.
// A Moore FSM walks each instruction through fetch, decode, execute, memory
// and write-back cycles, driving datapath selects and write enables, stalling
// on mem_ready, trapping unsupported opcodes and counting retired instructions.
// Optional feature: define JAL_EN to build the JAL state (opcode 111); without
// it, opcode 111 is treated as unsupported and traps to ILLEGAL.
module multicycle_control_fsm #(
   parameter int INSTRUCTION_LEN = 32,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [INSTRUCTION_LEN-1:0] instruction,
   input  logic                       mem_ready,
   input  logic                       zero,
   output logic                       pc_write,
   output logic                       ir_write,
   output logic                       adr_src,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic                       reg_write,
   output logic [1:0]                 result_src,
   output logic [1:0]                 alu_src_a,
   output logic [1:0]                 alu_src_b,
   output logic [1:0]                 alu_op,
   output logic                       illegal,
   output logic [3:0]                 state,
   output logic [CNT_WIDTH-1:0]       retired
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_ILLEGAL   = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_I      = 7'd19;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JAL    = 7'd111;

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_retire;
   logic [CNT_WIDTH-1:0] r_retired;
   logic [6:0]           w_opcode;
   logic                 w_unused_ir;

   assign w_opcode    = instruction[6:0];
   // Only the opcode field steers the sequencer; funct fields go to the ALU decoder.
   assign w_unused_ir = ^instruction[INSTRUCTION_LEN-1:7];

   // State register: reset aborts any instruction in flight and returns to FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so every
         // register samples the pre-edge values regardless of block ordering.
         r_state <= w_next_state;
      end
   end

   // Retired-instruction counter: bumps on the final transition of each instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_WIDTH'(1);
      end
   end

   // Next-state logic and retirement strobe.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can leave a value held (inferred latch).
      w_next_state = S_FETCH;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (w_opcode)
               OP_LOAD, OP_STORE: w_next_state = S_MEM_ADR;
               OP_R:              w_next_state = S_EXEC_R;
               OP_I:              w_next_state = S_EXEC_I;
               OP_BRANCH:         w_next_state = S_BRANCH;
`ifdef JAL_EN
               OP_JAL:            w_next_state = S_JAL;
`endif
               default:           w_next_state = S_ILLEGAL;
            endcase
         end
         S_MEM_ADR:   w_next_state = (w_opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         S_MEM_WRITE: begin
            if (mem_ready) begin
               w_next_state = S_FETCH;
               w_retire     = 1'b1;
            end else begin
               w_next_state = S_MEM_WRITE;
            end
         end
         S_EXEC_R:    w_next_state = S_ALU_WB;
         S_EXEC_I:    w_next_state = S_ALU_WB;
         S_ALU_WB: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         S_BRANCH: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
`ifdef JAL_EN
         S_JAL:       w_next_state = S_ALU_WB;
`endif
         S_ILLEGAL:   w_next_state = S_ILLEGAL;
         default:     w_next_state = S_FETCH;
      endcase
   end

   // Moore output decode; everything is held at 0 while reset is asserted so the
   // datapath sees no request even though the state register already reads FETCH.
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               // PC+4 and the new instruction are captured only when memory delivers.
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            S_MEM_ADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
               adr_src  = 1'b1;
               mem_read = 1'b1;
            end
            S_MEM_WB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = 2'b10;
            end
            S_ALU_WB: begin
               reg_write = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               pc_write  = zero;
            end
`ifdef JAL_EN
            S_JAL: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write  = 1'b1;
            end
`endif
            S_ILLEGAL: begin
               illegal = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
